muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit, downstream of the register file.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, Start/Busy/Done handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic              Flush,
  input  logic [2:0]        Funct3,
  input  logic [WIDTH-1:0]  Operand1,
  input  logic [WIDTH-1:0]  Operand2,
  input  logic [ADDR_W-1:0] DestReg,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Result,
  output logic [ADDR_W-1:0] ResultReg,
  output logic              RegWrite
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   rreg_q;
  logic                neg_q;
  logic [W-1:0]        opnd_q;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [CW-1:0]       cnt_q;
  logic [W-1:0]        res_q;
  logic                done_q, regwrite_q;

  // Start-time decode: sign flags, magnitudes and the no-iteration cases
  logic         is_div, sgn_div, s1, s2, neg_start, div_zero, div_ovf, special;
  logic [W-1:0] mag1, mag2, spec_res;
  logic [W-1:0] min_val;

  function automatic logic [W-1:0] mul_sel(input logic [2*W-1:0] prod, input logic neg,
                                           input logic [1:0] f);
    logic [2*W-1:0] p;
    p = neg ? -prod : prod;
    return (f == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  always_comb begin
    min_val   = {1'b1, {(W-1){1'b0}}};
    is_div    = Funct3[2];
    sgn_div   = is_div & ~Funct3[0];
    s1        = is_div ? (sgn_div & Operand1[W-1]) : ((^Funct3[1:0]) & Operand1[W-1]);
    s2        = is_div ? (sgn_div & Operand2[W-1]) : ((Funct3[1:0] == 2'b01) & Operand2[W-1]);
    mag1      = s1 ? -Operand1 : Operand1;
    mag2      = s2 ? -Operand2 : Operand2;
    neg_start = (is_div & Funct3[1]) ? s1 : (s1 ^ s2);
    div_zero  = is_div & (Operand2 == '0);
    div_ovf   = sgn_div & (Operand1 == min_val) & (Operand2 == '1);
    special   = div_zero | div_ovf;
    if (div_zero) spec_res = Funct3[1] ? Operand1 : '1;
    else          spec_res = Funct3[1] ? '0 : min_val;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) begin
      special  = 1'b1;
      spec_res = mul_sel({{W{1'b0}}, mag1} * {{W{1'b0}}, mag2}, neg_start, Funct3[1:0]);
    end
`endif
  end

  // One radix-2 step; the accumulator's low half holds the multiplier or dividend/quotient
  logic [W:0]   mul_sum;
  logic [W:0]   div_r;
  logic [W-1:0] div_sub;
  logic         div_ge;
  logic [W-1:0] res_fin, div_sel;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    div_r   = {acc_q[2*W-1:W], acc_q[W-1]};
    div_sub = div_r[W-1:0] - opnd_q;
    div_ge  = div_r >= {1'b0, opnd_q};
    if (f3_q[2])
      acc_d = {(div_ge ? div_sub : div_r[W-1:0]), acc_q[W-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[W-1:1]};
    div_sel = f3_q[1] ? acc_d[2*W-1:W] : acc_d[W-1:0];
    if (f3_q[2]) res_fin = neg_q ? -div_sel : div_sel;
    else         res_fin = mul_sel(acc_d, neg_q, f3_q[1:0]);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      rreg_q     <= '0;
      neg_q      <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      if (Flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (Start) begin
            f3_q   <= Funct3;
            rreg_q <= DestReg;
            neg_q  <= neg_start;
            opnd_q <= is_div ? mag2 : mag1;
            acc_q  <= {{W{1'b0}}, (is_div ? mag1 : mag2)};
            cnt_q  <= CW'(WIDTH);
            if (special) begin
              res_q   <= spec_res;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
          CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              res_q   <= res_fin;
              state_q <= DONE;
            end
          end
          DONE: begin
            done_q     <= 1'b1;
            regwrite_q <= (rreg_q != '0);
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign RegWrite  = regwrite_q;
  assign Result    = res_q;
  assign ResultReg = rreg_q;
endmodule
